// File: rtl/arbitro_rr.sv
// Registered round-robin arbiter with grant locking. The owner keeps the grant
// until it releases; MAX_HOLD bounds its tenure while others are waiting.
module arbitro_rr #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_num,
  output logic                 available
);
  localparam int IW = $clog2(N);
  localparam int HW = $clog2(MAX_HOLD + 1);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t        state;
  logic [HW-1:0] hold_cnt;
  logic [IW-1:0] ptr;

  logic [N-1:0]  cand;
  logic          keep;
  logic          win_vld;
  logic [IW-1:0] win_idx;
  logic [IW-1:0] win_nxt;

  // First set bit of r, searching upward from p with wrap.
  function automatic logic [IW-1:0] rr_sel(input logic [N-1:0] r, input logic [IW-1:0] p);
    logic          found;
    logic [IW-1:0] res;
    int            j;
    found = 1'b0;
    res   = '0;
    for (int i = 0; i < N; i++) begin
      j = int'(p) + i;
      if (j >= N) j = j - N;
      if (!found && r[j]) begin
        res   = IW'(j);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  // grant is zero in IDLE, so cand covers both a fresh pick and a handover/preempt.
  always_comb begin
    cand    = req & ~grant;
    keep    = (state == OWNED) && req[grant_num] &&
              ((hold_cnt < HW'(MAX_HOLD)) || (cand == '0));
    win_vld = |cand;
    win_idx = rr_sel(cand, ptr);
    win_nxt = (win_idx == IW'(N - 1)) ? '0 : win_idx + IW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= '0;
      grant_num <= '0;
      available <= 1'b1;
      hold_cnt  <= '0;
      ptr       <= '0;
    end else if (keep) begin
      if (hold_cnt != HW'(MAX_HOLD)) hold_cnt <= hold_cnt + HW'(1);
    end else if (win_vld) begin
      state     <= OWNED;
      grant     <= {{(N-1){1'b0}}, 1'b1} << win_idx;
      grant_num <= win_idx;
      available <= 1'b0;
      hold_cnt  <= HW'(1);
      ptr       <= win_nxt;
    end else begin
      state     <= IDLE;
      grant     <= '0;
      grant_num <= '0;
      available <= 1'b1;
      hold_cnt  <= '0;
    end
  end
endmodule

// File: tb/tb_arbitro_rr.sv
// Bench for arbitro_rr: two instances (MAX_HOLD=4 and MAX_HOLD=1) share req/rst
// and are compared every cycle against an owner/tenure/pointer model.
module tb_arbitro_rr;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic [N-1:0] g0, g1;
  logic [1:0]   n0, n1;
  logic         a0, a1;

  int errors = 0;
  int checks = 0;

  int m_own  [2];
  int m_hold [2];
  int m_ptr  [2];
  int m_max  [2] = '{4, 1};

  always #5 clk = ~clk;

  arbitro_rr #(.N(N), .MAX_HOLD(4)) dut0 (
    .clk(clk), .rst(rst), .req(req), .grant(g0), .grant_num(n0), .available(a0));
  arbitro_rr #(.N(N), .MAX_HOLD(1)) dut1 (
    .clk(clk), .rst(rst), .req(req), .grant(g1), .grant_num(n1), .available(a1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int d = 0; d < N; d++)
      if (r[(p + d) % N]) return (p + d) % N;
    return -1;
  endfunction

  // Reference: the owner keeps the resource while it asks, unless its tenure has
  // reached the limit and someone else waits; otherwise the next asker in
  // pointer order takes over, or the resource goes free.
  task automatic m_edge(input int d, input logic [N-1:0] r, input logic rs);
    logic [N-1:0] others;
    int w;
    if (rs) begin
      m_own[d] = -1; m_hold[d] = 0; m_ptr[d] = 0;
    end else if (m_own[d] < 0) begin
      w = pick(r, m_ptr[d]);
      if (w >= 0) begin
        m_own[d] = w; m_hold[d] = 1; m_ptr[d] = (w + 1) % N;
      end
    end else begin
      others = r & ~(4'(1) << m_own[d]);
      if (r[m_own[d]] && (m_hold[d] < m_max[d] || others == 0)) begin
        if (m_hold[d] < m_max[d]) m_hold[d]++;
      end else if (others != 0) begin
        w = pick(others, m_ptr[d]);
        m_own[d] = w; m_hold[d] = 1; m_ptr[d] = (w + 1) % N;
      end else begin
        m_own[d] = -1; m_hold[d] = 0;
      end
    end
  endtask

  task automatic chk_dut(input int d, input logic [N-1:0] g, input logic [1:0] n,
                         input logic a, input logic [N-1:0] r_dec);
    logic [N-1:0] eg;
    eg = (m_own[d] < 0) ? '0 : (4'(1) << m_own[d]);
    chk($sformatf("d%0d_grant", d), 32'(g), 32'(eg));
    chk($sformatf("d%0d_num", d), 32'(n), (m_own[d] < 0) ? 32'd0 : 32'(m_own[d]));
    chk($sformatf("d%0d_avail", d), 32'(a), 32'(m_own[d] < 0));
    chk($sformatf("d%0d_onehot", d), 32'($countones(g) <= 1), 32'd1);
    chk($sformatf("d%0d_avail_inv", d), 32'(a), 32'(g == '0));
    chk($sformatf("d%0d_num_inv", d), 32'(g), (g == '0) ? 32'd0 : 32'(4'(1) << n));
    chk($sformatf("d%0d_req_held", d), 32'((g & ~r_dec) == '0), 32'd1);
  endtask

  // One clock: apply inputs, update the model at the edge, compare just after it.
  task automatic step(input logic [N-1:0] r, input logic rs);
    req = r;
    rst = rs;
    @(posedge clk);
    m_edge(0, r, rs);
    m_edge(1, r, rs);
    #1;
    chk_dut(0, g0, n0, a0, rs ? '0 : r);
    chk_dut(1, g1, n1, a1, rs ? '0 : r);
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b1111;
    // Reset holds everything idle even with all requests up.
    step(4'b1111, 1'b1);
    step(4'b1111, 1'b1);
    chk("rst_grant", 32'(g0), 32'h0);
    chk("rst_avail", 32'(a0), 32'h1);
    // Constant full contention: tenure of 4 then rotation, 0..3 and back.
    for (int j = 0; j <= 16; j++) begin
      step(4'b1111, 1'b0);
      chk($sformatf("rot_%0d", j), 32'(g0), 32'(4'(1) << ((j / 4) % 4)));
      chk($sformatf("rot1_%0d", j), 32'(g1), 32'(4'(1) << (j % 4)));
    end

    // Lock and direct handover without an idle cycle.
    step(4'b0000, 1'b1);
    step(4'b0001, 1'b0);
    chk("lock_first", 32'(g0), 32'h1);
    step(4'b0011, 1'b0);
    step(4'b0011, 1'b0);
    chk("lock_hold", 32'(g0), 32'h1);
    step(4'b0010, 1'b0);
    chk("handover_grant", 32'(g0), 32'h2);
    chk("handover_num", 32'(n0), 32'h1);
    chk("handover_avail", 32'(a0), 32'h0);

    // Release to idle keeps the pointer; next search wraps from 3 to 0.
    step(4'b0000, 1'b1);
    step(4'b0100, 1'b0);
    step(4'b0000, 1'b0);
    chk("idle_grant", 32'(g0), 32'h0);
    chk("idle_avail", 32'(a0), 32'h1);
    step(4'b0011, 1'b0);
    chk("wrap_grant", 32'(g0), 32'h1);

    // Handover follows the pointer (3), not the lowest index.
    step(4'b0000, 1'b1);
    step(4'b0100, 1'b0);
    step(4'b1111, 1'b0);
    step(4'b1011, 1'b0);
    chk("fair_grant", 32'(g0), 32'h8);
    chk("fair_num", 32'(n0), 32'h3);
    step(4'b0011, 1'b0);
    chk("fair_next", 32'(g0), 32'h1);

    // Reset mid-grant clears the pointer too.
    step(4'b0000, 1'b1);
    step(4'b0100, 1'b0);
    step(4'b0110, 1'b0);
    step(4'b0110, 1'b1);
    chk("midrst_grant", 32'(g0), 32'h0);
    chk("midrst_avail", 32'(a0), 32'h1);
    step(4'b0110, 1'b0);
    chk("midrst_next", 32'(g0), 32'h2);

    // Random levels, with sticky phases so tenure limits are exercised.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      step(req, $urandom_range(0, 99) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
